mp_reset_sequencer: RTL and testbench

Synthesizable, parametrised bring-up sequencer for multi-pipeline FPGA tops. It replaces the fixed delay-and-pulse reset sequence used in single-pipeline benches. It waits for clock lock, then releases the system reset after a programmable delay. It then issues staggered per-channel CPU reset pulses to NCH pipelines, and supports warm restart and lock-loss recovery.

---
 rtl/mp_reset_sequencer_pkg.sv | 50 +++++
 rtl/mp_reset_sequencer_if.sv | 38 +++
 rtl/mp_reset_sequencer_dcnt.sv | 31 +++
 rtl/mp_reset_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_mp_reset_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mp_reset_sequencer_pkg.sv
// Shared types and helpers for the multi-pipeline reset sequencer.
// Optional build macro used by the slice: RSTSEQ_RESTART_CNT_EN.
package librstseq;

  localparam int MAX_CH = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYS_WAIT = 3'd1,
    CPU_WAIT = 3'd2,
    PULSE    = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5
  } rstseq_state_type;

  // Plain vector encodings keep the FSM register a simple logic [2:0]
  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_SYS_WAIT = SYS_WAIT;
  localparam logic [2:0] ST_CPU_WAIT = CPU_WAIT;
  localparam logic [2:0] ST_PULSE    = PULSE;
  localparam logic [2:0] ST_GAP      = GAP;
  localparam logic [2:0] ST_DONE     = DONE;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } nsb_t;

  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit of mask at or above index 'from'; from = 16 finds nothing
  function automatic nsb_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                        input logic [4:0]        from);
    nsb_t res;
    res.found = 1'b0;
    res.idx   = 4'd0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) begin
        res.found = 1'b1;
        res.idx   = 4'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mp_reset_sequencer_if.sv
// Control/status bundle between the sequencer and the FPGA top.
// restart_cnt exists only when RSTSEQ_RESTART_CNT_EN is defined.
interface mp_reset_sequencer_if #(
  parameter int NCH = 4
) ();
  import librstseq::*;

  localparam int CHW = ch_idx_width(NCH);

  logic           locked;
  logic [NCH-1:0] ch_en;
  logic           restart_req;
  logic           sys_rstn;
  logic [NCH-1:0] cpurst;
  logic           busy;
  logic           done;
  logic [CHW-1:0] cur_ch;
`ifdef RSTSEQ_RESTART_CNT_EN
  logic [7:0]     restart_cnt;
`endif

  modport master (
    output locked, ch_en, restart_req,
`ifdef RSTSEQ_RESTART_CNT_EN
    input  restart_cnt,
`endif
    input  sys_rstn, cpurst, busy, done, cur_ch
  );

  modport slave (
    input  locked, ch_en, restart_req,
`ifdef RSTSEQ_RESTART_CNT_EN
    output restart_cnt,
`endif
    output sys_rstn, cpurst, busy, done, cur_ch
  );

endinterface

// File: rtl/mp_reset_sequencer_dcnt.sv
// Loadable down counter shared by every timed state of the sequencer.
// Loading wins over counting; the count parks at zero.
module rstseq_dcnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_load,
  input  logic [CW-1:0] i_value,
  input  logic          i_en,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Count register: load, else decrement while enabled and non-zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mp_reset_sequencer.sv
// Bring-up sequencer: lock -> system reset release -> staggered CPU reset pulses.
// Define RSTSEQ_RESTART_CNT_EN to add the saturating restart_cnt status output.
module mp_reset_sequencer
  import librstseq::*;
#(
  parameter int NCH       = 4,
  parameter int SYS_DLY   = 200,
  parameter int CPU_DLY   = 200,
  parameter int PULSE_LEN = 10,
  parameter int STAGGER   = 0,
  parameter int CW        = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  mp_reset_sequencer_if.slave   bus
);

  localparam int CHW = ch_idx_width(NCH);

  localparam logic [CW-1:0] SYS_LD   = CW'(SYS_DLY - 1);
  localparam logic [CW-1:0] CPU_LD   = CW'(CPU_DLY - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((STAGGER > 0) ? (STAGGER - 1) : 0);

  logic [2:0]        r_state;
  logic [NCH-1:0]    r_mask;
  logic [CHW-1:0]    r_cur_ch;
  logic              r_sys_rstn;
  logic [NCH-1:0]    r_cpurst;
  logic              r_busy;
  logic              r_done;

  logic [2:0]        w_nxt_state;
  logic              w_load;
  logic [CW-1:0]     w_load_val;
  logic              w_cnt_en;
  logic              w_zero;
  logic              w_latch;
  logic              w_sel_new;
  logic [MAX_CH-1:0] w_mask_pad;
  logic [4:0]        w_sel_from;
  nsb_t              w_nsb;
  logic [CHW-1:0]    w_pulse_ch;
  logic [NCH-1:0]    w_onehot;
  logic              w_pulse_start;

  rstseq_dcnt #(
    .CW      (CW)
  ) u_dcnt (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_load),
    .i_value (w_load_val),
    .i_en    (w_cnt_en),
    .o_zero  (w_zero)
  );

  // Channel search: from 0 when leaving CPU_WAIT, above the current one otherwise
  always_comb begin
    w_mask_pad = '0;
    w_mask_pad[NCH-1:0] = r_mask;
    if (r_state == ST_PULSE) begin
      w_sel_from = 5'(r_cur_ch) + 5'd1;
    end else begin
      w_sel_from = 5'd0;
    end
    w_nsb = next_set_bit(w_mask_pad, w_sel_from);
  end

  // Next state and counter control; lock loss overrides every other event
  always_comb begin
    w_nxt_state = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_cnt_en    = 1'b0;
    w_latch     = 1'b0;
    w_sel_new   = 1'b0;
    if (!bus.locked && (r_state != ST_IDLE)) begin
      w_nxt_state = ST_IDLE;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.locked) begin
            w_nxt_state = ST_SYS_WAIT;
            w_load      = 1'b1;
            w_load_val  = SYS_LD;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end
        ST_SYS_WAIT: begin
          w_cnt_en = 1'b1;
          if (w_zero) begin
            w_nxt_state = ST_CPU_WAIT;
            w_load      = 1'b1;
            w_load_val  = CPU_LD;
            w_latch     = 1'b1;
          end else begin
            w_nxt_state = ST_SYS_WAIT;
          end
        end
        ST_CPU_WAIT: begin
          w_cnt_en = 1'b1;
          if (!w_zero) begin
            w_nxt_state = ST_CPU_WAIT;
          end else if (w_nsb.found) begin
            w_nxt_state = ST_PULSE;
            w_load      = 1'b1;
            w_load_val  = PULSE_LD;
            w_sel_new   = 1'b1;
          end else begin
            w_nxt_state = ST_DONE;
          end
        end
        ST_PULSE: begin
          w_cnt_en = 1'b1;
          if (!w_zero) begin
            w_nxt_state = ST_PULSE;
          end else if (!w_nsb.found) begin
            w_nxt_state = ST_DONE;
          end else if (STAGGER == 0) begin
            w_nxt_state = ST_PULSE;
            w_load      = 1'b1;
            w_load_val  = PULSE_LD;
            w_sel_new   = 1'b1;
          end else begin
            w_nxt_state = ST_GAP;
            w_load      = 1'b1;
            w_load_val  = GAP_LD;
            w_sel_new   = 1'b1;
          end
        end
        ST_GAP: begin
          w_cnt_en = 1'b1;
          if (w_zero) begin
            w_nxt_state = ST_PULSE;
            w_load      = 1'b1;
            w_load_val  = PULSE_LD;
          end else begin
            w_nxt_state = ST_GAP;
          end
        end
        ST_DONE: begin
          if (bus.restart_req) begin
            w_nxt_state = ST_CPU_WAIT;
            w_load      = 1'b1;
            w_load_val  = CPU_LD;
            w_latch     = 1'b1;
          end else begin
            w_nxt_state = ST_DONE;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_load      = 1'b1;
        end
      endcase
    end
  end

  // One-hot image of the channel whose pulse starts on this edge
  always_comb begin
    if (w_sel_new) begin
      w_pulse_ch = CHW'(w_nsb.idx);
    end else begin
      w_pulse_ch = r_cur_ch;
    end
    w_onehot = '0;
    w_onehot[w_pulse_ch] = 1'b1;
    w_pulse_start = w_load && (w_nxt_state == ST_PULSE);
  end

  // State, latched mask and outputs, all registered from the next-state decode
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_mask     <= '0;
      r_cur_ch   <= '0;
      r_sys_rstn <= 1'b0;
      r_cpurst   <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_mask     <= w_latch ? bus.ch_en : r_mask;
      r_cur_ch   <= w_pulse_ch;
      r_sys_rstn <= (w_nxt_state == ST_CPU_WAIT) || (w_nxt_state == ST_PULSE) ||
                    (w_nxt_state == ST_GAP)      || (w_nxt_state == ST_DONE);
      r_busy     <= (w_nxt_state != ST_DONE);
      r_done     <= (w_nxt_state == ST_DONE);
      if (w_nxt_state != ST_PULSE) begin
        r_cpurst <= '0;
      end else if (w_pulse_start) begin
        r_cpurst <= w_onehot;
      end else begin
        r_cpurst <= r_cpurst;
      end
    end
  end

  assign bus.sys_rstn = r_sys_rstn;
  assign bus.cpurst   = r_cpurst;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.cur_ch   = r_cur_ch;

`ifdef RSTSEQ_RESTART_CNT_EN
  logic       r_restart_cnt;
  logic [7:0] r_rcnt;
  logic       w_lock_loss;
  logic       w_restart;

  assign w_lock_loss = !bus.locked && (r_state != ST_IDLE);
  assign w_restart   = bus.locked && bus.restart_req && (r_state == ST_DONE);

  // Saturating count of accepted warm restarts and lock-loss recoveries
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rcnt <= 8'd0;
    end else if ((w_lock_loss || w_restart) && (r_rcnt != 8'hFF)) begin
      r_rcnt <= r_rcnt + 8'd1;
    end else begin
      r_rcnt <= r_rcnt;
    end
  end

  assign r_restart_cnt   = 1'b0;
  assign bus.restart_cnt = r_rcnt;
`endif

endmodule

// File: tb/tb_mp_reset_sequencer.sv
// Directed bench: dut_a uses default timing, dut_b a short STAGGER=3 profile.
// restart_cnt checks are active when RSTSEQ_RESTART_CNT_EN is defined.
module tb_mp_reset_sequencer;
  import librstseq::*;

  logic clk = 1'b0;
  logic rstn;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mp_reset_sequencer_if #(.NCH(4)) bus_a ();
  mp_reset_sequencer_if #(.NCH(4)) bus_b ();

  mp_reset_sequencer #(
    .NCH(4)
  ) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a.slave)
  );

  mp_reset_sequencer #(
    .NCH(4), .SYS_DLY(4), .CPU_DLY(3), .PULSE_LEN(2), .STAGGER(3), .CW(8)
  ) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // {sys_rstn, done, cpurst[3:0]} for dut_b after lock edge E+0 .. E+14
  logic [5:0] exp_b [15];

  initial begin
    exp_b = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
              6'b100000, 6'b100000, 6'b100000,
              6'b100010, 6'b100010,
              6'b100000, 6'b100000, 6'b100000,
              6'b101000, 6'b101000,
              6'b110000};

    rstn = 1'b0;
    bus_a.locked = 1'b0; bus_a.ch_en = 4'b0000; bus_a.restart_req = 1'b0;
    bus_b.locked = 1'b0; bus_b.ch_en = 4'b0000; bus_b.restart_req = 1'b0;
    step(2);
    chk("rst_sys_rstn", 32'(bus_a.sys_rstn), 32'd0);
    chk("rst_cpurst",   32'(bus_a.cpurst),   32'd0);
    chk("rst_busy",     32'(bus_a.busy),     32'd1);
    chk("rst_done",     32'(bus_a.done),     32'd0);
    chk("rst_cur_ch",   32'(bus_a.cur_ch),   32'd0);
    rstn = 1'b1;
    step(3);
    chk("idle_sys_rstn", 32'(bus_a.sys_rstn), 32'd0);
    chk("idle_busy",     32'(bus_a.busy),     32'd1);

    // STAGGER=3, mask 1010: ch1, three idle cycles, ch3
    bus_b.ch_en  = 4'b1010;
    bus_b.locked = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk($sformatf("stag_e%0d", i), 32'({bus_b.sys_rstn, bus_b.done, bus_b.cpurst}), 32'(exp_b[i]));
    end
    chk("stag_cur_ch", 32'(bus_b.cur_ch), 32'd3);

    // Empty mask: DONE the cycle after CPU_WAIT expiry, no pulses
    bus_b.ch_en = 4'b0000;
    bus_b.restart_req = 1'b1;
    step(1);
    bus_b.restart_req = 1'b0;
    chk("empty_r0", 32'({bus_b.sys_rstn, bus_b.busy, bus_b.done, bus_b.cpurst}), 32'b1100000);
    step(2);
    chk("empty_r2", 32'({bus_b.sys_rstn, bus_b.busy, bus_b.done, bus_b.cpurst}), 32'b1100000);
    step(1);
    chk("empty_r3", 32'({bus_b.sys_rstn, bus_b.busy, bus_b.done, bus_b.cpurst}), 32'b1010000);

    // Default timing, all channels; ch_en changed after latching has no effect
    bus_a.ch_en  = 4'b1111;
    bus_a.locked = 1'b1;
    step(200);
    chk("seq_sys_pre",  32'(bus_a.sys_rstn), 32'd0);
    step(1);
    chk("seq_sys_rise", 32'(bus_a.sys_rstn), 32'd1);
    bus_a.ch_en = 4'b0000;
    step(199);
    chk("seq_cpu_pre", 32'(bus_a.cpurst), 32'd0);
    step(1);
    for (int ch = 0; ch < 4; ch++) begin
      chk($sformatf("seq_ch%0d_first", ch), 32'(bus_a.cpurst), 32'(4'b0001 << ch));
      chk($sformatf("seq_ch%0d_cur",   ch), 32'(bus_a.cur_ch), 32'(ch));
      step(9);
      chk($sformatf("seq_ch%0d_last",  ch), 32'(bus_a.cpurst), 32'(4'b0001 << ch));
      step(1);
    end
    chk("seq_done", 32'({bus_a.done, bus_a.busy, bus_a.cpurst}), 32'b100000);

    // Warm restart with a single channel; restart_req during PULSE is ignored
    bus_a.ch_en = 4'b0001;
    bus_a.restart_req = 1'b1;
    step(1);
    bus_a.restart_req = 1'b0;
    chk("wr_state", 32'({bus_a.sys_rstn, bus_a.busy, bus_a.done}), 32'b110);
    step(199);
    chk("wr_cpu_pre", 32'(bus_a.cpurst), 32'd0);
    step(1);
    chk("wr_pulse", 32'(bus_a.cpurst), 32'b0001);
    bus_a.restart_req = 1'b1;
    step(1);
    bus_a.restart_req = 1'b0;
    step(8);
    chk("wr_pulse_end", 32'(bus_a.cpurst), 32'b0001);
    step(1);
    chk("wr_done", 32'({bus_a.done, bus_a.cpurst}), 32'b10000);
    step(5);
    chk("wr_stay_done", 32'({bus_a.done, bus_a.busy}), 32'b10);
`ifdef RSTSEQ_RESTART_CNT_EN
    chk("rcnt_wr", 32'(bus_a.restart_cnt), 32'd1);
`endif

    // One-cycle lock drop in the middle of the ch2 pulse
    bus_a.ch_en = 4'b1111;
    bus_a.restart_req = 1'b1;
    step(1);
    bus_a.restart_req = 1'b0;
    step(219);
    chk("ll_ch1", 32'(bus_a.cpurst), 32'b0010);
    step(1);
    chk("ll_ch2", 32'({bus_a.cur_ch, bus_a.cpurst}), 32'b10_0100);
    step(4);
    bus_a.locked = 1'b0;
    step(1);
    chk("ll_drop", 32'({bus_a.sys_rstn, bus_a.busy, bus_a.done, bus_a.cpurst}), 32'b0100000);
    bus_a.locked = 1'b1;
    step(200);
    chk("ll_sys_pre",  32'(bus_a.sys_rstn), 32'd0);
    step(1);
    chk("ll_sys_rise", 32'(bus_a.sys_rstn), 32'd1);
`ifdef RSTSEQ_RESTART_CNT_EN
    chk("rcnt_ll", 32'(bus_a.restart_cnt), 32'd3);
`endif
    step(200);
    chk("ll_ch0", 32'(bus_a.cpurst), 32'b0001);
    step(40);
    chk("ll_done", 32'({bus_a.done, bus_a.cur_ch}), 32'b111);

    // Async rstn in SYS_WAIT, mid-cycle, then a clean restart
    bus_a.locked = 1'b0;
    step(1);
    chk("ar_idle", 32'({bus_a.sys_rstn, bus_a.busy, bus_a.done}), 32'b010);
    bus_a.locked = 1'b1;
    step(50);
    chk("ar_pre_cur", 32'(bus_a.cur_ch), 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_sys_rstn", 32'(bus_a.sys_rstn), 32'd0);
    chk("ar_cpurst",   32'(bus_a.cpurst),   32'd0);
    chk("ar_busy",     32'(bus_a.busy),     32'd1);
    chk("ar_done",     32'(bus_a.done),     32'd0);
    chk("ar_cur_ch",   32'(bus_a.cur_ch),   32'd0);
    chk("ar_b_done",   32'(bus_b.done),     32'd0);
`ifdef RSTSEQ_RESTART_CNT_EN
    chk("rcnt_ar", 32'(bus_a.restart_cnt), 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    step(200);
    chk("ar_sys_pre",  32'(bus_a.sys_rstn), 32'd0);
    step(1);
    chk("ar_sys_rise", 32'(bus_a.sys_rstn), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
